// File: rtl/scarv_cop_aes_issue_if.sv
// ---------------------------------------------------------------------------
// scarv_cop_aes_issue_if
//
// Bundles every non-clock signal of the AES issue/writeback sequencer.
//   decode side   : dec_valid/dec_ready handshake, dec_rs1, dec_rs2,
//                   dec_subclass, dec_rd, flush
//   AES unit side : aes_ivalid, aes_rs1, aes_rs2, id_subclass (to unit);
//                   aes_idone, aes_cpr_rd_ben, aes_cpr_rd_wdata (from unit)
//   writeback     : wb_valid/wb_ready handshake, wb_rd, wb_ben, wb_wdata
//   status        : busy, err_timeout
//
// Modport master is the sequencer itself. Modport slave is the surrounding
// environment (decode, AES unit, writeback).
// ---------------------------------------------------------------------------
interface scarv_cop_aes_issue_if #(
  parameter int RD_W = 4
);
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_rs1;
  logic [31:0]     dec_rs2;
  logic [14:0]     dec_subclass;
  logic [RD_W-1:0] dec_rd;
  logic            flush;

  logic            aes_ivalid;
  logic [31:0]     aes_rs1;
  logic [31:0]     aes_rs2;
  logic [14:0]     id_subclass;
  logic            aes_idone;
  logic [3:0]      aes_cpr_rd_ben;
  logic [31:0]     aes_cpr_rd_wdata;

  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [3:0]      wb_ben;
  logic [31:0]     wb_wdata;

  logic            busy;
  logic            err_timeout;

  modport master (
    input  dec_valid, dec_rs1, dec_rs2, dec_subclass, dec_rd, flush,
    input  aes_idone, aes_cpr_rd_ben, aes_cpr_rd_wdata,
    input  wb_ready,
    output dec_ready,
    output aes_ivalid, aes_rs1, aes_rs2, id_subclass,
    output wb_valid, wb_rd, wb_ben, wb_wdata,
    output busy, err_timeout
  );

  modport slave (
    output dec_valid, dec_rs1, dec_rs2, dec_subclass, dec_rd, flush,
    output aes_idone, aes_cpr_rd_ben, aes_cpr_rd_wdata,
    output wb_ready,
    input  dec_ready,
    input  aes_ivalid, aes_rs1, aes_rs2, id_subclass,
    input  wb_valid, wb_rd, wb_ben, wb_wdata,
    input  busy, err_timeout
  );
endinterface

// File: rtl/scarv_cop_aes_issue.sv
// ---------------------------------------------------------------------------
// scarv_cop_aes_issue
//
// Issue/writeback sequencer in front of the coprocessor AES functional unit.
// One decoded instruction is accepted from decode, its operands are held on
// the AES unit inputs (with aes_ivalid high) until aes_idone, and the result
// is then offered to CPR writeback.
//
// Ports:
//   g_clk    clock
//   g_reset  asynchronous, active-high reset
//   bus      scarv_cop_aes_issue_if.master (decode, AES unit, writeback,
//            busy and err_timeout)
//
// The AES unit advances an internal 2-bit step counter on every cycle that
// aes_ivalid is high, so aes_ivalid is never withdrawn mid-operation: a flush
// only marks the instruction as discarded and the operation is run to
// completion. A timeout abandons operations that never complete (e.g. a
// non-AES subclass).
// ---------------------------------------------------------------------------
module scarv_cop_aes_issue #(
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 7
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  scarv_cop_aes_issue_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [31:0]     rs1_reg;
  logic [31:0]     rs2_reg;
  logic [14:0]     subclass_reg;
  logic [RD_W-1:0] rd_reg;
  logic [3:0]      ben_reg;
  logic [31:0]     wdata_reg;
  logic [2:0]      cnt_reg;
  logic            discard_reg;

  logic            ready_int;
  logic            accept;
  logic            timeout_hit;

  // Handshake and abort conditions shared by the FSM and the datapath.
  always_comb begin
    ready_int   = !bus.flush &&
                  ((state_reg == IDLE) ||
                   ((state_reg == WB) && bus.wb_ready && !discard_reg));
    accept      = bus.dec_valid && ready_int;
    timeout_hit = (state_reg == EXEC) && !bus.aes_idone &&
                  (cnt_reg == 3'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (bus.aes_idone) begin
          // A flush seen now or earlier kills the result but the AES unit
          // has still completed its full step sequence.
          state_next = (discard_reg || bus.flush) ? IDLE : WB;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      WB: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (bus.wb_ready) begin
          state_next = accept ? EXEC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand, result, step counter and discard registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      subclass_reg <= '0;
      rd_reg       <= '0;
      ben_reg      <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      discard_reg  <= 1'b0;
    end else begin
      if (accept) begin
        rs1_reg      <= bus.dec_rs1;
        rs2_reg      <= bus.dec_rs2;
        subclass_reg <= bus.dec_subclass;
        rd_reg       <= bus.dec_rd;
        cnt_reg      <= '0;
        discard_reg  <= 1'b0;
      end else if (state_reg == EXEC) begin
        // Saturate so a long TIMEOUT cannot wrap the counter.
        if (cnt_reg != 3'b111) begin
          cnt_reg <= cnt_reg + 3'd1;
        end
        if (bus.flush && !bus.aes_idone) begin
          discard_reg <= 1'b1;
        end
        if (bus.aes_idone) begin
          ben_reg   <= bus.aes_cpr_rd_ben;
          wdata_reg <= bus.aes_cpr_rd_wdata;
        end
      end
    end
  end

  // Outputs. Registered values are already zero during reset; dec_ready is
  // the only one that would otherwise be high in IDLE, so it is gated.
  assign bus.dec_ready   = ready_int && !g_reset;
  assign bus.aes_ivalid  = (state_reg == EXEC);
  assign bus.aes_rs1     = rs1_reg;
  assign bus.aes_rs2     = rs2_reg;
  assign bus.id_subclass = subclass_reg;
  assign bus.wb_valid    = (state_reg == WB) && !bus.flush;
  assign bus.wb_rd       = rd_reg;
  assign bus.wb_ben      = ben_reg;
  assign bus.wb_wdata    = wdata_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.err_timeout = timeout_hit;

endmodule

// File: tb/tb_scarv_cop_aes_issue.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_aes_issue
//
// Bench for scarv_cop_aes_issue. Contains a behavioural AES unit (2-bit step
// counter advancing while aes_ivalid is high, aes_idone on the 4th step) and a
// writeback scoreboard fed when instructions are issued.
// ---------------------------------------------------------------------------
module tb_scarv_cop_aes_issue;
  localparam int RD_W = 4;
  localparam logic [14:0] SUB_ENC    = 15'h0001;
  localparam logic [14:0] SUB_ENCMIX = 15'h0002;

  logic g_clk   = 1'b0;
  logic g_reset = 1'b0;
  always #5 g_clk = ~g_clk;

  scarv_cop_aes_issue_if #(.RD_W(RD_W)) bus ();

  scarv_cop_aes_issue #(.RD_W(RD_W), .TIMEOUT(7)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [3:0]      ben;
    logic [31:0]     wdata;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // ---------------- AES unit model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] aes_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [14:0] sub);
    if (sub == SUB_ENC)
      return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    return a ^ {b[23:0], b[31:24]};
  endfunction

  logic [1:0] aes_step;
  logic       aes_known;
  logic       force_idone = 1'b0;

  assign aes_known = |bus.id_subclass[3:0];

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) aes_step <= 2'd0;
    else if (bus.aes_ivalid && aes_known) aes_step <= aes_step + 2'd1;
  end

  assign bus.aes_idone        = (bus.aes_ivalid && aes_known && aes_step == 2'd3) || force_idone;
  assign bus.aes_cpr_rd_ben   = bus.aes_idone ? 4'hF : 4'h0;
  assign bus.aes_cpr_rd_wdata = bus.aes_idone ? aes_fn(bus.aes_rs1, bus.aes_rs2, bus.id_subclass)
                                              : 32'hDEADBEEF;

  // ---------------- writeback scoreboard ----------------
  wb_t got_wb;
  wb_t exp_wb;
  always @(negedge g_clk) begin
    #2;
    if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
      got_wb = {bus.wb_rd, bus.wb_ben, bus.wb_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got rd=%0d wdata=%h required no writeback", got_wb.rd, got_wb.wdata);
      end else begin
        exp_wb = exp_q.pop_front();
        if (got_wb !== exp_wb) begin
          errors++;
          $display("FAIL wb_result got rd=%0d ben=%h wdata=%h required rd=%0d ben=%h wdata=%h",
                   got_wb.rd, got_wb.ben, got_wb.wdata, exp_wb.rd, exp_wb.ben, exp_wb.wdata);
        end else begin
          $display("wb rd=%0d ben=%h wdata=%h", got_wb.rd, got_wb.ben, got_wb.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge g_clk);
  endtask

  task automatic drive_dec(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [14:0] sub, input logic [RD_W-1:0] rd);
    bus.dec_valid    = v;
    bus.dec_rs1      = a;
    bus.dec_rs2      = b;
    bus.dec_subclass = sub;
    bus.dec_rd       = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 g_reset = 1'b1;
    tick(); #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready got=%b want=0", bus.dec_ready); end
    checks++; if (bus.aes_ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid got=%b want=0", bus.aes_ivalid); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b want=0", bus.wb_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.wb_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", bus.wb_wdata); end
    tick(); g_reset = 1'b0; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", bus.dec_ready); end
    $display("test_reset done");
  endtask

  task automatic test_enc_sub();
    tick();
    drive_dec(1'b1, 32'h0, 32'h0, SUB_ENC, 4'd3);
    bus.wb_ready = 1'b1;
    exp_q.push_back({4'd3, 4'hF, 32'h63636363});
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL enc_accept got=%b want=1", bus.dec_ready); end
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 1) bus.dec_valid = 1'b0; #1;
      checks++; if (bus.aes_ivalid !== 1'b1) begin errors++; $display("FAIL enc_ivalid_%0d got=%b want=1", k, bus.aes_ivalid); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL enc_early_wb_%0d got=%b want=0", k, bus.wb_valid); end
      checks++; if (bus.id_subclass !== SUB_ENC) begin errors++; $display("FAIL enc_subclass_%0d got=%h want=%h", k, bus.id_subclass, SUB_ENC); end
    end
    tick(); #1;
    checks++; if (bus.aes_ivalid !== 1'b0) begin errors++; $display("FAIL enc_ivalid_5 got=%b want=0", bus.aes_ivalid); end
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL enc_wb_valid got=%b want=1", bus.wb_valid); end
    checks++; if (bus.wb_wdata !== 32'h63636363) begin errors++; $display("FAIL enc_wdata got=%h want=63636363", bus.wb_wdata); end
    tick(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL enc_idle got busy=%b want=0", bus.busy); end
    $display("test_enc_sub done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_w;
    exp_w = aes_fn(32'h01C0FF53, 32'h0, SUB_ENC);
    tick();
    drive_dec(1'b1, 32'h01C0FF53, 32'h0, SUB_ENC, 4'd5);
    bus.wb_ready = 1'b0;
    exp_q.push_back({4'd5, 4'hF, exp_w});
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 1) bus.dec_valid = 1'b0; #1;
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL stall_exec_ready_%0d got=%b want=0", k, bus.dec_ready); end
    end
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL stall_wb_valid_%0d got=%b want=1", k, bus.wb_valid); end
      checks++; if (bus.wb_wdata !== exp_w) begin errors++; $display("FAIL stall_wdata_%0d got=%h want=%h", k, bus.wb_wdata, exp_w); end
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d got=%b want=0", k, bus.dec_ready); end
    end
    tick(); bus.wb_ready = 1'b1; #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy_hs got=%b want=1", bus.busy); end
    tick(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_busy_after got=%b want=0", bus.busy); end
    $display("test_stall done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    a1 = 32'h01234567; b1 = 32'h89ABCDEF; a2 = 32'hDEADBEEF; b2 = 32'h0BADF00D;
    tick();
    drive_dec(1'b1, a1, b1, SUB_ENCMIX, 4'd1);
    bus.wb_ready = 1'b1;
    exp_q.push_back({4'd1, 4'hF, a1 ^ {b1[23:0], b1[31:24]}});
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        drive_dec(1'b1, a2, b2, SUB_ENCMIX, 4'd2);
        exp_q.push_back({4'd2, 4'hF, a2 ^ {b2[23:0], b2[31:24]}});
      end
      #1;
      checks++; if (bus.aes_rs1 !== a1) begin errors++; $display("FAIL b2b_rs1a_%0d got=%h want=%h", k, bus.aes_rs1, a1); end
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_exec_%0d got=%b want=0", k, bus.dec_ready); end
    end
    tick(); #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb1 got=%b want=1", bus.wb_valid); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept2 got=%b want=1", bus.dec_ready); end
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 1) bus.dec_valid = 1'b0; #1;
      checks++; if (bus.aes_ivalid !== 1'b1) begin errors++; $display("FAIL b2b_ivalid2_%0d got=%b want=1", k, bus.aes_ivalid); end
      checks++; if (bus.aes_rs2 !== b2) begin errors++; $display("FAIL b2b_rs2b_%0d got=%h want=%h", k, bus.aes_rs2, b2); end
    end
    tick(); #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb2 got=%b want=1", bus.wb_valid); end
    tick(); #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drained got=%0d pending want=0", exp_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    tick();
    drive_dec(1'b1, 32'h11223344, 32'h55667788, SUB_ENC, 4'd7);
    bus.wb_ready = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) bus.dec_valid = 1'b0;
      bus.flush = (k == 2);
      #1;
      checks++; if (bus.aes_ivalid !== 1'b1) begin errors++; $display("FAIL flush_ivalid_%0d got=%b want=1", k, bus.aes_ivalid); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_%0d got=%b want=0", k, bus.wb_valid); end
    end
    tick(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b want=0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wb got=%b want=0", bus.wb_valid); end
    // Follow-up op: exact latency and value show the AES step count stayed aligned.
    tick();
    drive_dec(1'b1, 32'h0, 32'h0, SUB_ENC, 4'd9);
    exp_q.push_back({4'd9, 4'hF, 32'h63636363});
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 1) bus.dec_valid = 1'b0; #1;
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL align_early_wb_%0d got=%b want=0", k, bus.wb_valid); end
    end
    tick(); #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL align_wb got=%b want=1", bus.wb_valid); end
    checks++; if (bus.wb_wdata !== 32'h63636363) begin errors++; $display("FAIL align_wdata got=%h want=63636363", bus.wb_wdata); end
    tick(); #1;
    $display("test_flush done");
  endtask

  task automatic test_idle_events();
    tick();
    drive_dec(1'b1, 32'hA5A5A5A5, 32'h0, SUB_ENC, 4'd2);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL idle_flush_ready got=%b want=0", bus.dec_ready); end
    tick(); bus.dec_valid = 1'b0; bus.flush = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_flush_no_accept got busy=%b want=0", bus.busy); end
    force_idone = 1'b1;
    tick(); force_idone = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stray_idone_busy got=%b want=0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stray_idone_wb got=%b want=0", bus.wb_valid); end
    $display("test_idle_events done");
  endtask

  task automatic test_timeout();
    tick();
    drive_dec(1'b1, 32'h12345678, 32'h9ABCDEF0, 15'h0000, 4'd4);
    #1;
    for (int k = 1; k <= 7; k++) begin
      tick(); if (k == 1) bus.dec_valid = 1'b0; #1;
      checks++; if (bus.aes_ivalid !== 1'b1) begin errors++; $display("FAIL to_ivalid_%0d got=%b want=1", k, bus.aes_ivalid); end
      checks++; if (bus.err_timeout !== (k == 7)) begin errors++; $display("FAIL to_err_%0d got=%b want=%b", k, bus.err_timeout, (k == 7)); end
    end
    tick(); #1;
    checks++; if (bus.aes_ivalid !== 1'b0) begin errors++; $display("FAIL to_ivalid_after got=%b want=0", bus.aes_ivalid); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_after got=%b want=0", bus.err_timeout); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL to_ready_after got=%b want=1", bus.dec_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL to_no_wb got=%b want=0", bus.wb_valid); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    tick();
    drive_dec(1'b1, 32'hCAFEF00D, 32'h13579BDF, SUB_ENC, 4'd6);
    #1;
    tick(); bus.dec_valid = 1'b0; #1;
    tick(); #1;
    checks++; if (bus.aes_ivalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ivalid got=%b want=1", bus.aes_ivalid); end
    #2 g_reset = 1'b1;
    #1;
    checks++; if (bus.aes_ivalid !== 1'b0) begin errors++; $display("FAIL rstmid_ivalid got=%b want=0", bus.aes_ivalid); end
    checks++; if (bus.aes_rs1 !== 32'h0) begin errors++; $display("FAIL rstmid_rs1 got=%h want=0", bus.aes_rs1); end
    checks++; if (bus.id_subclass !== 15'h0) begin errors++; $display("FAIL rstmid_sub got=%h want=0", bus.id_subclass); end
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b want=0", bus.dec_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    checks++; if (bus.wb_rd !== 4'h0) begin errors++; $display("FAIL rstmid_wb_rd got=%h want=0", bus.wb_rd); end
    tick(); g_reset = 1'b0; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready got=%b want=1", bus.dec_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_release_busy got=%b want=0", bus.busy); end
    $display("test_reset_mid done");
  endtask

  initial begin
    drive_dec(1'b0, 32'h0, 32'h0, 15'h0, '0);
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b0;
    test_reset();
    test_enc_sub();
    test_stall();
    test_back_to_back();
    test_flush();
    test_idle_events();
    test_timeout();
    test_reset_mid();
    tick(); tick(); #3;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain got=%0d pending want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
